// File: rtl/feedback_blinker.sv
// feedback_blinker: turns single-cycle press events into a visible LED blink
// pattern. A short press queues one blink, a long press queues three. Queued
// blinks are held in a saturating 4-bit pending counter and played back as
// ON_CYCLES lit / OFF_CYCLES dark pulses, back to back while work remains.
module feedback_blinker #(
  parameter int ON_CYCLES  = 12500000,
  parameter int OFF_CYCLES = 12500000,
  parameter int CTR_LEN    = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic short_evt,
  input  logic long_evt,
  output logic led,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam logic [CTR_LEN-1:0] ON_LAST  = CTR_LEN'(ON_CYCLES - 1);
  localparam logic [CTR_LEN-1:0] OFF_LAST = CTR_LEN'(OFF_CYCLES - 1);

  state_t             state;
  logic [CTR_LEN-1:0] ctr;
  logic [3:0]         pend;
  logic [3:0]         pend_next;
  logic [5:0]         pend_sum;
  logic               take;
  logic               on_done;
  logic               off_done;

  assign on_done  = (ctr == ON_LAST);
  assign off_done = (ctr == OFF_LAST);

  // A blink starts either from IDLE or straight out of the final OFF cycle;
  // both decisions look at the registered queue, not at this cycle's events.
  always_comb begin
    take = 1'b0;
    if (pend != 4'd0) begin
      if (state == IDLE) begin
        take = 1'b1;
      end else if (state == OFF && off_done) begin
        take = 1'b1;
      end
    end
  end

  // Queue update: add new requests, remove the one being started, then
  // clamp at 15. Six bits leave headroom for 15 + 1 + 3 without wrapping,
  // and take is only ever high when pend is nonzero, so no underflow.
  always_comb begin
    pend_sum  = {2'b00, pend}
              + {5'b00000, short_evt}
              + (long_evt ? 6'd3 : 6'd0)
              - {5'b00000, take};
    pend_next = (pend_sum > 6'd15) ? 4'd15 : pend_sum[3:0];
  end

  // Blink sequencer: state, duration counter, queue and the registered LED.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ctr   <= '0;
      pend  <= 4'd0;
      led   <= 1'b0;
    end else begin
      pend <= pend_next;
      case (state)
        IDLE: begin
          if (pend != 4'd0) begin
            state <= ON;
            ctr   <= '0;
            led   <= 1'b1;
          end
        end
        ON: begin
          if (on_done) begin
            state <= OFF;
            ctr   <= '0;
            led   <= 1'b0;
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        OFF: begin
          if (off_done) begin
            ctr <= '0;
            if (pend != 4'd0) begin
              state <= ON;
              led   <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ctr   <= '0;
          led   <= 1'b0;
        end
      endcase
    end
  end

  // Busy covers both the blink in flight and anything still queued.
  assign busy = (state != IDLE) | (pend != 4'd0);

endmodule

// File: tb/tb_feedback_blinker.sv
// Directed bench for feedback_blinker with ON_CYCLES=4, OFF_CYCLES=3.
// Cycle n means the outputs visible after rising edge n; an input driven
// during cycle n is sampled at edge n+1.
module tb_feedback_blinker;

  localparam int ON_C  = 4;
  localparam int OFF_C = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic short_evt = 1'b0;
  logic long_evt = 1'b0;
  logic led;
  logic busy;

  feedback_blinker #(
    .ON_CYCLES (ON_C),
    .OFF_CYCLES(OFF_C),
    .CTR_LEN   (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .short_evt(short_evt),
    .long_evt (long_evt),
    .led      (led),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic s;
    logic l;
    logic exp_led;
    logic exp_busy;
  } vec_t;

  vec_t vecs[0:23];

  int n_pass  = 0;
  int n_total = 0;
  int t       = 0;
  int rise_at[$];
  int wbad    = 0;
  logic prev_led = 1'b0;
  int busy_fall = -1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
      $display("check %-22s t=%0d act=%0d exp=%0d ok", name, t, act, exp);
    end else begin
      $display("FAIL %-22s t=%0d actual=%0d required=%0d", name, t, act, exp);
    end
  endtask

  // Advance one cycle and track LED rises and pulse widths.
  task automatic step();
    @(posedge clk);
    #1;
    t++;
    if (led && !prev_led) rise_at.push_back(t);
    if (!led && prev_led && rise_at.size() > 0) begin
      if (t - rise_at[rise_at.size()-1] != ON_C) wbad++;
    end
    prev_led = led;
  endtask

  task automatic go_to(input int c);
    while (t < c) step();
  endtask

  task automatic pulse(input logic s, input logic l);
    short_evt = s;
    long_evt  = l;
    step();
    short_evt = 1'b0;
    long_evt  = 1'b0;
  endtask

  task automatic clear_mon();
    rise_at.delete();
    wbad     = 0;
    prev_led = led;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    t = 0;
    clear_mon();
  endtask

  // Run until busy drops, bounded; records the cycle busy was first low.
  task automatic watch(input int budget);
    int n;
    n = 0;
    busy_fall = -1;
    while (busy && n < budget) begin
      step();
      n++;
    end
    if (busy) chk("watch_timeout", 1, 0);
    else busy_fall = t;
  endtask

  function automatic int period_bad();
    int b;
    b = 0;
    for (int i = 1; i < rise_at.size(); i++)
      if (rise_at[i] - rise_at[i-1] != ON_C + OFF_C) b++;
    return b;
  endfunction

  function automatic int rise_n(input int i);
    return (i < rise_at.size()) ? rise_at[i] : -1;
  endfunction

  initial begin
    int late;
    int seen;

    // Single short press during cycle 10: busy 11..18, led 12..15.
    for (int i = 0; i < 24; i++) begin
      vecs[i].s        = (i == 10);
      vecs[i].l        = 1'b0;
      vecs[i].exp_led  = (i >= 12 && i <= 15);
      vecs[i].exp_busy = (i >= 11 && i <= 18);
    end

    // Reset state.
    do_reset();
    chk("reset_led", int'(led), 0);
    chk("reset_busy", int'(busy), 0);

    // Table-driven single short blink.
    for (int i = 0; i < 24; i++) begin
      short_evt = vecs[i].s;
      long_evt  = vecs[i].l;
      chk($sformatf("tbl_led[%0d]", i), int'(led), int'(vecs[i].exp_led));
      chk($sformatf("tbl_busy[%0d]", i), int'(busy), int'(vecs[i].exp_busy));
      step();
    end
    short_evt = 1'b0;
    chk("tbl_nrise", rise_at.size(), 1);

    // Long press: three blinks at 12, 19, 26; busy low from 33.
    do_reset();
    go_to(10);
    pulse(1'b0, 1'b1);
    watch(100);
    chk("long_nrise", rise_at.size(), 3);
    chk("long_rise0", rise_n(0), 12);
    chk("long_rise1", rise_n(1), 19);
    chk("long_rise2", rise_n(2), 26);
    chk("long_width_bad", wbad, 0);
    chk("long_busy_fall", busy_fall, 33);

    // Both events together: four blinks, 7-cycle period, idle at 40.
    do_reset();
    go_to(10);
    pulse(1'b1, 1'b1);
    watch(100);
    chk("both_nrise", rise_at.size(), 4);
    chk("both_rise0", rise_n(0), 12);
    chk("both_period_bad", period_bad(), 0);
    chk("both_width_bad", wbad, 0);
    chk("both_busy_fall", busy_fall, 40);

    // Short press during ON: pulse unchanged, extra blink right after OFF.
    do_reset();
    go_to(10);
    pulse(1'b1, 1'b0);
    go_to(13);
    chk("on_mid_led", int'(led), 1);
    pulse(1'b1, 1'b0);
    watch(100);
    chk("on_nrise", rise_at.size(), 2);
    chk("on_rise1", rise_n(1), 19);
    chk("on_width_bad", wbad, 0);
    chk("on_busy_fall", busy_fall, 26);

    // Event in the final OFF cycle is missed by the exit decision and
    // starts through IDLE one cycle later.
    do_reset();
    go_to(10);
    pulse(1'b1, 1'b0);
    go_to(18);
    chk("lastoff_led", int'(led), 0);
    chk("lastoff_busy", int'(busy), 1);
    pulse(1'b1, 1'b0);
    chk("lastoff_idle_busy", int'(busy), 1);
    chk("lastoff_idle_led", int'(led), 0);
    watch(100);
    chk("lastoff_nrise", rise_at.size(), 2);
    chk("lastoff_rise1", rise_n(1), 20);
    chk("lastoff_busy_fall", busy_fall, 27);

    // Six long presses on consecutive cycles 10..15. The first blink is
    // taken at edge 12 while the burst is still arriving; the queue then
    // clamps at 15, so 15 blinks follow the one already started.
    do_reset();
    go_to(10);
    for (int k = 0; k < 6; k++) pulse(1'b0, 1'b1);
    watch(300);
    late = 0;
    foreach (rise_at[i]) if (rise_at[i] > 16) late++;
    chk("sat_nrise_total", rise_at.size(), 16);
    chk("sat_nrise_after_burst", late, 15);
    chk("sat_period_bad", period_bad(), 0);
    chk("sat_width_bad", wbad, 0);
    chk("sat_busy_fall", busy_fall, 124);

    // Reset in the second ON cycle with two blinks still queued; a press
    // in the reset cycle is dropped.
    do_reset();
    go_to(10);
    pulse(1'b0, 1'b1);
    go_to(13);
    chk("rstmid_led_before", int'(led), 1);
    rst       = 1'b1;
    short_evt = 1'b1;
    step();
    rst       = 1'b0;
    short_evt = 1'b0;
    chk("rstmid_led", int'(led), 0);
    chk("rstmid_busy", int'(busy), 0);
    clear_mon();
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (led || busy) seen++;
    end
    chk("rstmid_quiet", seen, 0);
    pulse(1'b1, 1'b0);
    watch(100);
    chk("rstmid_new_nrise", rise_at.size(), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
